// File: rtl/demux_pkg.sv
// Shared constants and presentation-state encoding for the 1-to-8 serial demultiplexer.
package demux_pkg;
  localparam int NSLOT  = 8;
  localparam int SLOT_W = $clog2(NSLOT);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } pres_state_e;
endpackage

// File: rtl/deser_out_stage.sv
// Presentation stage: holds the completed byte until the consumer takes it and
// flags bytes that complete while the previous one is still waiting.
module deser_out_stage
  import demux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_complete,
  input  logic [W-1:0] i_byte,
  input  logic         i_ready,
  input  logic         i_sync,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_overrun
);

  pres_state_e  r_state;
  logic [W-1:0] r_data;
  logic         r_overrun;
  logic         w_drop;

  assign w_drop = i_complete && (r_state == FULL) && !i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_complete) begin
            r_data  <= i_byte;
            r_state <= FULL;
          end
        end
        FULL: begin
          // A pop and a push in the same cycle swap bytes with no valid gap.
          if (i_ready) begin
            if (i_complete) r_data <= i_byte;
            else            r_state <= EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
      // A drop wins over sync so the loss is never silently erased.
      if (w_drop)      r_overrun <= 1'b1;
      else if (i_sync) r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = (r_state == FULL);
  assign o_overrun = r_overrun;

endmodule

// File: rtl/demux_1_to_8_deser.sv
// Serial-to-byte demultiplexer: routes accepted bits to slots (auto-increment or
// external select), completes a byte when every slot has been written.
module demux_1_to_8_deser #(
  parameter int NSLOT = demux_pkg::NSLOT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in,
  input  logic                        in_valid,
  input  logic                        sync,
  input  logic                        sel_mode,
  input  logic [demux_pkg::SLOT_W-1:0] sel,
  output logic [NSLOT-1:0]            out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [demux_pkg::SLOT_W-1:0] slot,
  output logic                        overrun
);
  import demux_pkg::*;

  logic [NSLOT-1:0]  r_collect;
  logic [NSLOT-1:0]  r_mask;
  logic [SLOT_W-1:0] r_slot;

  logic [NSLOT-1:0]  w_mask_base;
  logic [SLOT_W-1:0] w_slot_base;
  logic [SLOT_W-1:0] w_idx;
  logic [NSLOT-1:0]  w_collect;
  logic [NSLOT-1:0]  w_mask;
  logic              w_complete;

  // Sync clears first, so a bit accepted alongside it starts the new frame.
  always_comb begin
    w_mask_base = sync ? '0 : r_mask;
    w_slot_base = sync ? '0 : r_slot;
    w_idx       = sel_mode ? sel : w_slot_base;
    w_collect   = r_collect;
    w_mask      = w_mask_base;
    if (in_valid) begin
      w_collect[w_idx] = in;
      w_mask[w_idx]    = 1'b1;
    end
    w_complete = in_valid && (&w_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_collect <= '0;
      r_mask    <= '0;
      r_slot    <= '0;
    end else begin
      r_collect <= w_collect;
      r_mask    <= w_complete ? '0 : w_mask;
      r_slot    <= (in_valid && !sel_mode) ? w_slot_base + 1'b1 : w_slot_base;
    end
  end

  deser_out_stage #(.W(NSLOT)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_complete (w_complete),
    .i_byte     (w_collect),
    .i_ready    (out_ready),
    .i_sync     (sync),
    .o_data     (out),
    .o_valid    (out_valid),
    .o_overrun  (overrun)
  );

  assign slot = r_slot;

endmodule

// File: tb/tb_demux_1_to_8_deser.sv
// Directed bench for demux_1_to_8_deser with a per-cycle behavioural model check.
module tb_demux_1_to_8_deser;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in, in_valid, sync, sel_mode, out_ready;
  logic [2:0] sel;
  logic [7:0] out;
  logic       out_valid, overrun;
  logic [2:0] slot;

  int n_chk = 0;
  int n_fail = 0;

  demux_1_to_8_deser #(.NSLOT(8)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid), .sync(sync),
    .sel_mode(sel_mode), .sel(sel), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .slot(slot), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Model: slot bits and written flags as arrays; presented byte as a 1-deep
  // holding buffer that is popped before the new byte tries to enter.
  bit   m_bits [8];
  bit   m_seen [8];
  int   m_slot;
  int   m_out;
  bit   m_valid;
  bit   m_ovr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin m_bits[k] = 0; m_seen[k] = 0; end
      m_slot = 0; m_out = 0; m_valid = 0; m_ovr = 0;
    end else begin
      int  idx, cnt, byte_v;
      bit  done;
      if (sync) begin
        for (int k = 0; k < 8; k++) m_seen[k] = 0;
        m_slot = 0;
        m_ovr  = 0;
      end
      done = 0;
      if (in_valid) begin
        idx = sel_mode ? int'(sel) : m_slot;
        m_bits[idx] = in;
        m_seen[idx] = 1;
        if (!sel_mode) m_slot = (m_slot + 1) % 8;
        cnt = 0;
        for (int k = 0; k < 8; k++) cnt += m_seen[k];
        done = (cnt == 8);
      end
      byte_v = 0;
      for (int k = 0; k < 8; k++) byte_v += int'(m_bits[k]) * (1 << k);
      if (done) for (int k = 0; k < 8; k++) m_seen[k] = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (done) begin
        if (!m_valid) begin m_out = byte_v; m_valid = 1; end
        else m_ovr = 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model.out",       out,              8'(m_out));
    chk("model.out_valid", {7'd0, out_valid}, {7'd0, m_valid});
    chk("model.slot",      {5'd0, slot},      8'(m_slot));
    chk("model.overrun",   {7'd0, overrun},   {7'd0, m_ovr});
  end

  task automatic cyc(input logic iv, input logic b, input logic sm,
                     input logic [2:0] s, input logic sy, input logic rdy);
    in_valid = iv; in = b; sel_mode = sm; sel = s; sync = sy; out_ready = rdy;
    @(posedge clk); #1;
    in_valid = 0; in = 0; sync = 0;
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 0; in = 0; in_valid = 0; sync = 0; sel_mode = 0; sel = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst.out", out, 8'h00);
    chk("rst.valid", {7'd0, out_valid}, 8'h00);
    chk("rst.slot", {5'd0, slot}, 8'h00);

    // auto mode, consumer ready
    pat = 8'b01001101;
    for (int i = 0; i < 7; i++) cyc(1, pat[i], 0, 3'd0, 0, 1);
    chk("auto.not_yet", {7'd0, out_valid}, 8'h00);
    cyc(1, pat[7], 0, 3'd0, 0, 1);
    chk("auto.out", out, 8'h4D);
    chk("auto.valid", {7'd0, out_valid}, 8'h01);
    chk("auto.slot_wrap", {5'd0, slot}, 8'h00);
    cyc(0, 0, 0, 3'd0, 0, 1);
    chk("auto.popped", {7'd0, out_valid}, 8'h00);

    // external mode with a repeated slot, consumer stalled
    for (int s = 7; s >= 3; s--) cyc(1, s == 3, 1, 3'(s), 0, 0);
    cyc(1, 1, 1, 3'd3, 0, 0);
    chk("ext.no_early", {7'd0, out_valid}, 8'h00);
    for (int s = 2; s >= 0; s--) cyc(1, 0, 1, 3'(s), 0, 0);
    chk("ext.out", out, 8'h08);
    chk("ext.slot_kept", {5'd0, slot}, 8'h00);

    // second byte while stalled is dropped
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 3'd0, 0, 0);
    chk("bp.out_held", out, 8'h08);
    chk("bp.overrun", {7'd0, overrun}, 8'h01);
    cyc(0, 0, 0, 3'd0, 1, 0);
    chk("bp.sync_clr", {7'd0, overrun}, 8'h00);
    chk("bp.sync_valid", {7'd0, out_valid}, 8'h01);

    // pop and push in the same cycle
    pat = 8'hA5;
    for (int i = 0; i < 7; i++) cyc(1, pat[i], 0, 3'd0, 0, 0);
    cyc(1, pat[7], 0, 3'd0, 0, 1);
    chk("sim.out", out, 8'hA5);
    chk("sim.valid", {7'd0, out_valid}, 8'h01);
    chk("sim.overrun", {7'd0, overrun}, 8'h00);
    cyc(0, 0, 0, 3'd0, 0, 1);

    // sync mid-frame together with a bit
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 3'd0, 0, 1);
    cyc(1, 1, 0, 3'd0, 1, 1);
    chk("sync.slot", {5'd0, slot}, 8'h01);
    pat = 8'b0000_0110;
    for (int i = 0; i < 7; i++) cyc(1, pat[i], 0, 3'd0, 0, 1);
    chk("sync.out", out, 8'h0D);
    chk("sync.valid", {7'd0, out_valid}, 8'h01);
    cyc(0, 0, 0, 3'd0, 0, 1);

    // reset mid-frame with a byte presented
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) cyc(1, pat[i], 0, 3'd0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 1, 0, 3'd0, 0, 0);
    chk("rmid.slot_before", {5'd0, slot}, 8'h05);
    #1 rst_n = 0;
    #1;
    chk("rmid.out", out, 8'h00);
    chk("rmid.valid", {7'd0, out_valid}, 8'h00);
    chk("rmid.slot", {5'd0, slot}, 8'h00);
    chk("rmid.overrun", {7'd0, overrun}, 8'h00);
    @(posedge clk); #1 rst_n = 1;
    pat = 8'h03;
    for (int i = 0; i < 7; i++) cyc(1, pat[i], 0, 3'd0, 0, 0);
    chk("rmid.no_early", {7'd0, out_valid}, 8'h00);
    cyc(1, pat[7], 0, 3'd0, 0, 0);
    chk("rmid.out2", out, 8'h03);
    chk("rmid.valid2", {7'd0, out_valid}, 8'h01);

    repeat (3) cyc(0, 0, 0, 3'd0, 0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
